// File: rtl/cache_bus_pkg.sv
// Shared encodings for the cache-to-memory arbiter: FSM states, grant IDs, fixed refill attributes.
package cache_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_t;

  localparam logic       GNT_I     = 1'b0;
  localparam logic       GNT_D     = 1'b1;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [3:0] WEN_ALL   = 4'hF;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache-side and memory-side bus of the arbiter; master is the arbiter's view, slave is the
// view of whoever sits around it (caches plus bus bridge).
interface cache_mem_arbiter_if #(parameter int A_WIDTH = 32);
  logic [A_WIDTH-1:0] i_a;
  logic               i_strobe;
  logic [31:0]        i_din;
  logic               i_ready;

  logic [A_WIDTH-1:0] d_a;
  logic [31:0]        d_dout;
  logic [3:0]         d_wen;
  logic [1:0]         d_size;
  logic               d_rw;
  logic               d_strobe;
  logic [31:0]        d_din;
  logic               d_ready;

  logic [A_WIDTH-1:0] m_a;
  logic [31:0]        m_din;
  logic [3:0]         m_wen;
  logic [1:0]         m_size;
  logic               m_rw;
  logic               m_strobe;
  logic [31:0]        m_dout;
  logic               m_ready;

  logic               bus_err;

  modport master (
    input  i_a, i_strobe, d_a, d_dout, d_wen, d_size, d_rw, d_strobe, m_dout, m_ready,
    output i_din, i_ready, d_din, d_ready, m_a, m_din, m_wen, m_size, m_rw, m_strobe, bus_err
  );

  modport slave (
    output i_a, i_strobe, d_a, d_dout, d_wen, d_size, d_rw, d_strobe, m_dout, m_ready,
    input  i_din, i_ready, d_din, d_ready, m_a, m_din, m_wen, m_size, m_rw, m_strobe, bus_err
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker, purely combinational: on contention the side that did not
// win last time gets the grant.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (&req) gnt[~last] = 1'b1;
    else      gnt = req;
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single memory port between I-cache refills and D-cache accesses, holding the
// granted request on m_* until m_ready or watchdog expiry.
module cache_mem_arbiter
  import cache_bus_pkg::*;
#(
  parameter int A_WIDTH   = 32,
  parameter int TO_CYCLES = 255,
  parameter int TO_W      = 8
) (
  input  logic             clk,
  input  logic             clrn,
  cache_mem_arbiter_if.master bus
);

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TO_CYCLES == 0 ? 0 : TO_CYCLES - 1);

  state_t             state, state_nx;
  logic               last_grant;
  logic [1:0]         req, gnt;
  logic [TO_W-1:0]    wd_cnt;
  logic               busy, timeout, done;

  logic [A_WIDTH-1:0] m_a_q;
  logic [31:0]        m_din_q;
  logic [3:0]         m_wen_q;
  logic [1:0]         m_size_q;
  logic               m_rw_q, m_strobe_q, bus_err_q;

  assign req = {bus.d_strobe, bus.i_strobe};

  rr_arb2 u_arb (
    .req  (req),
    .last (last_grant),
    .gnt  (gnt)
  );

  assign busy = (state != ST_IDLE);
  // Expiry fires in the cycle the count would reach TO_CYCLES; a same-cycle m_ready wins.
  assign timeout = (TO_CYCLES != 0) && busy && !bus.m_ready && (wd_cnt == WD_LAST);
  assign done    = busy && (bus.m_ready || timeout);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (gnt[GNT_I])      state_nx = ST_BUSY_I;
        else if (gnt[GNT_D]) state_nx = ST_BUSY_D;
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (done) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.i_ready = 1'b0;
    bus.i_din   = '0;
    bus.d_ready = 1'b0;
    bus.d_din   = '0;
    if (state == ST_BUSY_I && done) begin
      bus.i_ready = 1'b1;
      bus.i_din   = bus.m_ready ? bus.m_dout : 32'h0;
    end
    if (state == ST_BUSY_D && done) begin
      bus.d_ready = 1'b1;
      bus.d_din   = bus.m_ready ? bus.m_dout : 32'h0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      m_a_q      <= '0;
      m_din_q    <= '0;
      m_wen_q    <= '0;
      m_size_q   <= '0;
      m_rw_q     <= 1'b0;
      m_strobe_q <= 1'b0;
      last_grant <= GNT_D;
      wd_cnt     <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      bus_err_q <= timeout;
      if (state == ST_IDLE) begin
        if (gnt[GNT_I]) begin
          m_a_q      <= bus.i_a;
          m_din_q    <= '0;
          m_wen_q    <= WEN_ALL;
          m_size_q   <= SIZE_WORD;
          m_rw_q     <= 1'b0;
          m_strobe_q <= 1'b1;
          last_grant <= GNT_I;
          wd_cnt     <= '0;
        end else if (gnt[GNT_D]) begin
          m_a_q      <= bus.d_a;
          m_din_q    <= bus.d_dout;
          m_wen_q    <= bus.d_wen;
          m_size_q   <= bus.d_size;
          m_rw_q     <= bus.d_rw;
          m_strobe_q <= 1'b1;
          last_grant <= GNT_D;
          wd_cnt     <= '0;
        end
      end else begin
        if (done) m_strobe_q <= 1'b0;
        if (!bus.m_ready) wd_cnt <= wd_cnt + TO_W'(1);
      end
    end
  end

  assign bus.m_a      = m_a_q;
  assign bus.m_din    = m_din_q;
  assign bus.m_wen    = m_wen_q;
  assign bus.m_size   = m_size_q;
  assign bus.m_rw     = m_rw_q;
  assign bus.m_strobe = m_strobe_q;
  assign bus.bus_err  = bus_err_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: reset/contention sequence, a vector table of
// single transactions (including watchdog cases) and an asynchronous mid-transaction reset.
module tb_cache_mem_arbiter;

  localparam int TO = 4;

  typedef struct {
    logic        side;      // 0 = I, 1 = D
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wen;
    logic [1:0]  size;
    logic        rw;
    logic [31:0] rdata;
    int          ack_cycle; // busy cycle carrying m_ready, 0 = never
    logic        drop;      // drop strobe right after grant
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] din;
    logic [3:0]  wen;
    logic [1:0]  size;
    logic        rw;
  } mexp_t;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  mexp_t sb[$];
  vec_t  vecs[6];

  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.A_WIDTH(32)) bif ();

  cache_mem_arbiter #(.A_WIDTH(32), .TO_CYCLES(TO), .TO_W(8)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bif)
  );

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [95:0] pk(input mexp_t e);
    return 96'({e.a, e.din, e.wen, e.size, e.rw});
  endfunction

  function automatic logic [95:0] mbus();
    return 96'({bif.m_a, bif.m_din, bif.m_wen, bif.m_size, bif.m_rw});
  endfunction

  function automatic mexp_t exp_of(input vec_t v);
    mexp_t e;
    e.a = v.addr;
    if (v.side) begin
      e.din = v.wdata; e.wen = v.wen; e.size = v.size; e.rw = v.rw;
    end else begin
      e.din = 32'h0; e.wen = 4'hF; e.size = 2'b10; e.rw = 1'b0;
    end
    return e;
  endfunction

  task automatic wait_grant(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bif.m_strobe && lat < 8);
    chk("grant_latency", 96'(lat), 96'(1));
  endtask

  task automatic run_vec(input vec_t v);
    mexp_t e;
    int lat, rc;
    logic [31:0] exp_din;
    @(negedge clk);
    if (v.side) begin
      bif.d_a = v.addr; bif.d_dout = v.wdata; bif.d_wen = v.wen;
      bif.d_size = v.size; bif.d_rw = v.rw; bif.d_strobe = 1'b1;
    end else begin
      bif.i_a = v.addr; bif.i_strobe = 1'b1;
    end
    sb.push_back(exp_of(v));
    wait_grant(lat);
    if (sb.size() == 0) begin
      chk("sb_empty", 96'(1), 96'(0));
      return;
    end
    e = sb.pop_front();
    rc = (v.ack_cycle != 0) ? v.ack_cycle : TO;
    exp_din = (v.ack_cycle != 0) ? v.rdata : 32'h0;
    bif.m_dout = v.rdata;
    for (int c = 1; c <= rc; c++) begin
      if (c > 1) @(negedge clk);
      chk("m_strobe_busy", 96'(bif.m_strobe), 96'(1));
      chk("m_hold", mbus(), pk(e));
      if (c == 1) begin
        bif.d_a = $urandom; bif.d_dout = $urandom; bif.i_a = $urandom;
        bif.d_wen = 4'($urandom); bif.d_rw = ~bif.d_rw;
        if (v.drop) begin
          bif.i_strobe = 1'b0; bif.d_strobe = 1'b0;
        end
      end
      bif.m_ready = (c == v.ack_cycle);
      #1;
      chk(v.side ? "d_ready" : "i_ready", 96'(v.side ? bif.d_ready : bif.i_ready), 96'(c == rc));
      chk(v.side ? "i_ready_other" : "d_ready_other", 96'(v.side ? bif.i_ready : bif.d_ready), 96'(0));
      if (c == rc) chk(v.side ? "d_din" : "i_din", 96'(v.side ? bif.d_din : bif.i_din), 96'(exp_din));
    end
    @(negedge clk);
    bif.m_ready = 1'b0; bif.i_strobe = 1'b0; bif.d_strobe = 1'b0;
    chk("m_strobe_after", 96'(bif.m_strobe), 96'(0));
    chk("bus_err_pulse", 96'(bif.bus_err), 96'(v.ack_cycle == 0));
    @(negedge clk);
    chk("bus_err_clear", 96'(bif.bus_err), 96'(0));
    chk("m_strobe_idle", 96'(bif.m_strobe), 96'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    mexp_t e;
    logic side;

    vecs[0] = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b0011, 2'b01, 1'b1, 32'h0,         3, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_1000, 32'h0,         4'h0,    2'b00, 1'b0, 32'h1234_5678, 1, 1'b0};
    vecs[2] = '{1'b1, 32'h2000_0040, 32'h5555_AAAA, 4'hF,    2'b10, 1'b0, 32'hA5A5_0F0F, 2, 1'b1};
    vecs[3] = '{1'b1, 32'h3000_0000, 32'h0,         4'hF,    2'b10, 1'b0, 32'hCAFE_F00D, 0, 1'b0};
    vecs[4] = '{1'b1, 32'h3000_0004, 32'h0,         4'hF,    2'b10, 1'b0, 32'h0BAD_F00D, 4, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_2004, 32'h0,         4'h0,    2'b00, 1'b0, 32'h7777_1111, 2, 1'b1};

    // Reset held with both sides requesting and a stray m_ready.
    bif.i_a = 32'h0000_0100; bif.i_strobe = 1'b1;
    bif.d_a = 32'h0000_0200; bif.d_dout = 32'h1111_2222; bif.d_wen = 4'b1100;
    bif.d_size = 2'b01; bif.d_rw = 1'b1; bif.d_strobe = 1'b1;
    bif.m_dout = 32'h9999_9999; bif.m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_m_strobe", 96'(bif.m_strobe), 96'(0));
    chk("rst_i_ready", 96'(bif.i_ready), 96'(0));
    chk("rst_d_ready", 96'(bif.d_ready), 96'(0));
    chk("rst_m_bus", mbus(), 96'(0));
    chk("rst_bus_err", 96'(bif.bus_err), 96'(0));

    // Continuous contention: grants alternate I, D, I, D starting with I.
    for (int k = 0; k < 4; k++) begin
      e.a    = (k % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
      e.din  = (k % 2 == 0) ? 32'h0 : 32'h1111_2222;
      e.wen  = (k % 2 == 0) ? 4'hF : 4'b1100;
      e.size = (k % 2 == 0) ? 2'b10 : 2'b01;
      e.rw   = (k % 2 == 0) ? 1'b0 : 1'b1;
      sb.push_back(e);
    end
    bif.m_ready = 1'b0;
    clrn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_grant(lat);
      e = sb.pop_front();
      side = (k % 2 == 1);
      chk("cont_m_bus", mbus(), pk(e));
      bif.m_dout = 32'hC000_0000 + 32'(k);
      bif.m_ready = 1'b1;
      #1;
      chk("cont_i_ready", 96'(bif.i_ready), 96'(!side));
      chk("cont_d_ready", 96'(bif.d_ready), 96'(side));
      chk("cont_din", 96'(side ? bif.d_din : bif.i_din), 96'(32'hC000_0000 + 32'(k)));
      @(negedge clk);
      bif.m_ready = 1'b0;
      if (k == 3) begin
        bif.i_strobe = 1'b0; bif.d_strobe = 1'b0;
      end
      chk("cont_idle_gap", 96'(bif.m_strobe), 96'(0));
      chk("cont_no_ready", 96'({bif.i_ready, bif.d_ready}), 96'(0));
    end

    // Stray m_ready while idle is ignored.
    @(negedge clk);
    bif.m_dout = 32'hFFFF_0000; bif.m_ready = 1'b1;
    #1;
    chk("stray_ready", 96'({bif.i_ready, bif.d_ready}), 96'(0));
    chk("stray_din", 96'({bif.i_din, bif.d_din}), 96'(0));
    @(negedge clk);
    bif.m_ready = 1'b0;
    chk("stray_no_grant", 96'(bif.m_strobe), 96'(0));

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Asynchronous reset in the middle of a D transaction.
    @(negedge clk);
    bif.d_a = 32'h0000_0300; bif.d_dout = 32'h3333_4444; bif.d_wen = 4'hF;
    bif.d_size = 2'b10; bif.d_rw = 1'b1; bif.d_strobe = 1'b1;
    wait_grant(lat);
    chk("mid_m_a", 96'(bif.m_a), 96'(32'h0000_0300));
    #2;
    clrn = 1'b0; bif.m_ready = 1'b1; bif.m_dout = 32'h5555_6666;
    #1;
    chk("mid_rst_strobe", 96'(bif.m_strobe), 96'(0));
    chk("mid_rst_m_bus", mbus(), 96'(0));
    chk("mid_rst_ready", 96'({bif.i_ready, bif.d_ready}), 96'(0));
    @(negedge clk);
    bif.m_ready = 1'b0; bif.d_strobe = 1'b0; clrn = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 96'(bif.m_strobe), 96'(0));
    run_vec(vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single external memory port between the instruction cache (read-only refill) and the data cache (miss refill plus write-through).
- Sits between the two caches' memory-side interfaces and the bus bridge.
- Serialises requests, alternates grants when both sides contend, and holds each transaction's address, data and control stable until the memory acknowledges.
- A watchdog terminates hung transactions so the pipeline cannot deadlock.

Parameters:
- A_WIDTH, 32, address width of all ports.
- TO_CYCLES, 255, watchdog limit in cycles spent in a BUSY state; 0 disables the watchdog.
- TO_W, 8, width of the watchdog counter; TO_CYCLES must be less than 2^TO_W.

Ports:
- clk  in  1  clock
- clrn  in  1  reset, asynchronous, active-low
- i_a  in  A_WIDTH  instruction-side address
- i_strobe  in  1  instruction-side request (always a read)
- i_din  out  32  read data to instruction cache
- i_ready  out  1  instruction transaction done
- d_a  in  A_WIDTH  data-side address
- d_dout  in  32  write data from data cache
- d_wen  in  4  byte enables
- d_size  in  2  access size
- d_rw  in  1  0 read, 1 write
- d_strobe  in  1  data-side request
- d_din  out  32  read data to data cache
- d_ready  out  1  data transaction done
- m_a  out  A_WIDTH  memory address
- m_din  out  32  memory write data
- m_wen  out  4  byte enables
- m_size  out  2  access size
- m_rw  out  1  read/write
- m_strobe  out  1  memory request
- m_dout  in  32  memory read data
- m_ready  in  1  memory acknowledge (single-cycle pulse)
- bus_err  out  1  one-cycle pulse on watchdog expiry

Behaviour:

FSM states:
- IDLE, BUSY_I, BUSY_D.
- Reset (clrn low, asynchronous) forces: state IDLE, m_strobe 0, m_a 0, m_din 0, m_wen 0, m_size 0, m_rw 0, last_grant D, watchdog count 0, bus_err 0.

IDLE:
- Samples the strobes and grants at most one requester.
- Only i_strobe high -> BUSY_I.
- Only d_strobe high -> BUSY_D.
- Both high -> grant the side not equal to last_grant. First contention after reset therefore goes to I.
- Neither high -> stay in IDLE.

On a grant, the following registers are loaded in the same edge:
- m_a from the granted address.
- For D: m_din=d_dout, m_wen=d_wen, m_size=d_size, m_rw=d_rw.
- For I: m_din=0, m_wen=4'b1111, m_size=2'b10, m_rw=0.
- m_strobe=1 and last_grant=<granted side>.
- The watchdog count is cleared.

BUSY_x:
- All m_* outputs are held constant, whatever the requester inputs do.
- The watchdog increments each cycle in which m_ready is 0.

Completion:
- On m_ready=1 while in BUSY_x: x_ready=1 and x_din=m_dout combinationally in that same cycle; the other side's ready stays 0.
- Next edge: state IDLE, m_strobe 0.
- Ready and read data are never forwarded outside the matching BUSY state, so a stray m_ready in IDLE is ignored.

Timeout:
- If TO_CYCLES!=0 and the count reaches TO_CYCLES: x_ready=1 with x_din=0 in that cycle, bus_err=1 for one cycle (registered, visible the next cycle).
- Next edge: state IDLE, m_strobe 0.
- m_ready arriving in the same cycle as expiry takes precedence: normal completion, no error.

Latency and throughput:
- Grant occurs one cycle after the strobe is seen in IDLE.
- Minimum request-to-ready time is 2 cycles (grant edge, then m_ready in the first BUSY cycle).
- At least one IDLE cycle separates consecutive transactions, so requesters must drop or update their strobe after ready.

Requester rules:
- A strobe deasserted while its side is granted does not abort the transaction. It completes on the memory side, and the ready pulse is still produced and may be ignored.
- A write from D and a refill from I are never merged or reordered. Each strobe gets exactly one ready.

Decomposition:
- Shared package cache_bus_pkg holds:
  - State encodings ST_IDLE=2'd0, ST_BUSY_I=2'd1, ST_BUSY_D=2'd2.
  - Grant IDs GNT_I=1'b0, GNT_D=1'b1.
  - Constants SIZE_WORD=2'b10 and WEN_ALL=4'hF.
- One sub-module is natural: rr_arb2, a 2-way round-robin picker (req[1:0], last, gnt[1:0]), purely combinational. Everything else lives in the top.

Test Plan:
1. Reset: hold clrn=0 with both strobes high -> m_strobe=0, i_ready=d_ready=0; release clrn, first edge -> BUSY_I (I wins first contention), m_a=i_a.
2. Single D write: d_a=0x8000_0010, d_dout=0xDEADBEEF, d_wen=4'b0011, d_rw=1, memory acks 3 cycles after m_strobe -> m_* stable throughout, d_ready one cycle coincident with m_ready, m_strobe=0 next cycle.
3. Contention: both strobes held high continuously, memory acks in 1 cycle -> grants alternate I,D,I,D with one IDLE cycle between; each ready pulses once per grant.
4. I refill read: m_dout=0x1234_5678 on ack -> i_din=0x1234_5678 with i_ready=1 in the same cycle; d_ready stays 0.
5. Watchdog with TO_CYCLES=4 and no m_ready -> after 4 BUSY cycles d_ready=1, d_din=0, bus_err pulses once, FSM returns to IDLE; a repeat with m_ready arriving on the 4th cycle -> no bus_err.
6. Mid-transaction async reset: clrn low during BUSY_D -> m_strobe drops immediately without waiting for a clock, no ready is issued, and after release the FSM restarts from IDLE.
